// File: rtl/dma_loader.sv
// dma_loader: host byte-stream loader into weight/input/instruction buffers with single writes, START and bursts.
// Burst mode (BURST state, counter, busy, burst_done) is built only when DMA_LOADER_BURST_EN is defined.
module dma_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16,
  parameter int NUM_CH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        uio_in,
  input  logic [DATA_W-1:0] ui_in,
  output logic [NUM_CH-1:0] wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              start,
  output logic              busy,
  output logic              burst_done,
  output logic              err
);
  localparam logic [2:0] OP_START = 3'd4, OP_BEGIN = 3'd5, OP_ABORT = 3'd6, OP_RSV = 3'd7;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [2:0] NCH_L = 3'(NUM_CH);
  logic [2:0] op, sch;
  logic [ADDR_W-1:0] addr;
  logic single, single_ok, prev_start, in_burst, begin_ok, unused_bits;
  logic [NUM_CH-1:0] wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [DATA_W-1:0] wr_data_n;
  logic start_n, busy_n, done_n, err_n;
  assign op = uio_in[7:5];
  assign addr = uio_in[ADDR_W-1:0];
  assign sch = op - 3'd1;
  assign single = op inside {3'd1, 3'd2, 3'd3};
  assign single_ok = (sch < NCH_L) && ({1'b0, addr} < DEPTH_L);
  assign unused_bits = ^uio_in;
`ifdef DMA_LOADER_BURST_EN
  localparam logic [ADDR_W:0] LAST_L = (ADDR_W+1)'(DEPTH - 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_n;
  logic [1:0] ch, ch_n;
  logic strobe, last;
  assign strobe = uio_in[4];
  assign last = {1'b0, cnt} == LAST_L;
  assign in_burst = state == BURST;
  assign begin_ok = {1'b0, uio_in[1:0]} < NCH_L;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      ch <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      ch <= ch_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    ch_n = ch;
    if (!in_burst && op == OP_BEGIN && begin_ok) begin
      state_n = BURST;
      cnt_n = '0;
      ch_n = uio_in[1:0];
    end else if (in_burst && op == OP_ABORT) state_n = IDLE;
    else if (in_burst && strobe) begin
      state_n = last ? IDLE : BURST;
      cnt_n = last ? cnt : cnt + ADDR_W'(1);
    end
  end
`else
  assign in_burst = 1'b0;
  assign begin_ok = 1'b0;
`endif
  always_comb begin
    wr_en_n = '0;
    wr_addr_n = wr_addr;
    wr_data_n = wr_data;
    done_n = 1'b0;
    busy_n = 1'b0;
    err_n = err;
    start_n = !in_burst && op == OP_START && !prev_start;
    if (!in_burst) begin
      if (single && single_ok) begin
        wr_en_n = NUM_CH'(1) << sch;
        wr_addr_n = addr;
        wr_data_n = ui_in;
      end
      err_n = err | (single && !single_ok) | (op == OP_RSV) | (op == OP_BEGIN && !begin_ok);
      busy_n = op == OP_BEGIN && begin_ok;
    end
`ifdef DMA_LOADER_BURST_EN
    else if (op != OP_ABORT) begin
      if (strobe) begin
        wr_en_n = NUM_CH'(1) << ch;
        wr_addr_n = cnt;
        wr_data_n = ui_in;
        done_n = last;
      end
      busy_n = !(strobe && last);
      err_n = err | (op inside {3'd1, 3'd2, 3'd3, OP_START, OP_RSV});
    end
`endif
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_en <= '0;
      wr_addr <= '0;
      wr_data <= '0;
      start <= 1'b0;
      busy <= 1'b0;
      burst_done <= 1'b0;
      err <= 1'b0;
      prev_start <= 1'b0;
    end else begin
      wr_en <= wr_en_n;
      wr_addr <= wr_addr_n;
      wr_data <= wr_data_n;
      start <= start_n;
      busy <= busy_n;
      burst_done <= done_n;
      err <= err_n;
      prev_start <= op == OP_START;
    end
endmodule

// File: tb/tb_dma_loader.sv
// tb_dma_loader: directed and randomized checks of dma_loader against a behavioural model.
module tb_dma_loader;
`ifdef DMA_LOADER_BURST_EN
  localparam bit BURST_ON = 1'b1;
`else
  localparam bit BURST_ON = 1'b0;
`endif
  localparam int NCH = 3, DEP = 16;
  logic clk = 0, reset = 0;
  logic [7:0] uio_in = 0, ui_in = 0, uio2 = 0, ui2 = 0;
  logic [2:0] wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic start, busy, burst_done, err;
  logic [1:0] we2;
  logic [3:0] wa2;
  logic [7:0] wd2;
  logic st2, bz2, bd2, er2;
  int n_chk = 0, n_fail = 0;
  bit m_burst, m_err, m_prev4;
  int m_cnt, m_ch;
  logic [2:0] e_we;
  logic [3:0] e_addr;
  logic [7:0] e_data;
  logic e_start, e_busy, e_done, e_err;

  always #5 clk = ~clk;

  dma_loader dut (.clk(clk), .reset(reset), .uio_in(uio_in), .ui_in(ui_in), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .start(start), .busy(busy), .burst_done(burst_done), .err(err));
  dma_loader #(.NUM_CH(2), .DEPTH(10)) dut2 (.clk(clk), .reset(reset), .uio_in(uio2), .ui_in(ui2),
    .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .start(st2), .busy(bz2), .burst_done(bd2), .err(er2));

  task automatic mreset;
    m_burst = 0; m_err = 0; m_prev4 = 0; m_cnt = 0; m_ch = 0;
  endtask

  // Expected outputs for the cycle after (u, d) are sampled, from the opcode rules.
  task automatic model(input logic [7:0] u, input logic [7:0] d);
    int op, a, c;
    op = int'(u[7:5]); a = int'(u[3:0]); c = int'(u[1:0]);
    e_we = 0; e_start = 0; e_done = 0;
    if (!m_burst) begin
      if (op >= 1 && op <= 3) begin
        if (op - 1 < NCH && a < DEP) begin e_we = 3'(1 << (op - 1)); e_addr = 4'(a); e_data = d; end
        else m_err = 1;
      end else if (op == 4) e_start = !m_prev4;
      else if (op == 5) begin
        if (BURST_ON && c < NCH) begin m_burst = 1; m_cnt = 0; m_ch = c; end
        else m_err = 1;
      end else if (op == 7) m_err = 1;
    end else if (op == 6) m_burst = 0;
    else begin
      if (u[4]) begin
        e_we = 3'(1 << m_ch); e_addr = 4'(m_cnt); e_data = d;
        if (m_cnt == DEP - 1) begin e_done = 1; m_burst = 0; end
        else m_cnt++;
      end
      if (op inside {1, 2, 3, 4, 7}) m_err = 1;
    end
    m_prev4 = op == 4;
    e_busy = m_burst; e_err = m_err;
  endtask

  task automatic cycle(input logic [7:0] u, input logic [7:0] d);
    uio_in = u; ui_in = d; model(u, d);
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    uio_in = 0; uio2 = 0; reset = 1; mreset();
    #2 reset = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #1 reset = 1;
    #2;
    n_chk++;
    if ({wr_en, wr_addr, wr_data, start, busy, burst_done, err} !== 19'd0)
      begin n_fail++; $display("FAIL reset_state: got %h want 0", {wr_en, wr_addr, wr_data, start, busy, burst_done, err}); end
    n_chk++;
    if ({we2, st2, bz2, bd2, er2} !== 6'd0) begin n_fail++; $display("FAIL reset_state2: got %h want 0", {we2, st2, bz2, bd2, er2}); end
    reset = 0; mreset();
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    cycle(8'b001_0_0101, 8'hA5);
    n_chk++;
    if ({wr_en, wr_addr, wr_data, err} !== {3'b001, 4'd5, 8'hA5, 1'b0})
      begin n_fail++; $display("FAIL single_wr: got %h want %h", {wr_en, wr_addr, wr_data, err}, {3'b001, 4'd5, 8'hA5, 1'b0}); end
    cycle(8'b011_0_1111, 8'h3C);
    cycle(8'b011_0_1111, 8'h3D);
    n_chk++;
    if ({wr_en, wr_addr, wr_data} !== {3'b100, 4'd15, 8'h3D})
      begin n_fail++; $display("FAIL single_hold: got %h want %h", {wr_en, wr_addr, wr_data}, {3'b100, 4'd15, 8'h3D}); end
    cycle(8'h00, 8'h00);
    n_chk++;
    if (wr_en !== 3'b000) begin n_fail++; $display("FAIL single_nop: got %b want 000", wr_en); end
  endtask

  task automatic test_start;
    logic [3:0] got;
    cycle(8'h80, 0); got[0] = start;
    cycle(8'h80, 0); got[1] = start;
    cycle(8'h80, 0); got[2] = start;
    cycle(8'h00, 0); got[3] = start;
    n_chk++;
    if (got !== 4'b0001) begin n_fail++; $display("FAIL start_run: got %b want 0001", got); end
    cycle(8'h80, 0);
    n_chk++;
    if (start !== 1'b1) begin n_fail++; $display("FAIL start_again: got %b want 1", start); end
    cycle(8'h00, 0);
    n_chk++;
    if (start !== 1'b0) begin n_fail++; $display("FAIL start_fall: got %b want 0", start); end
  endtask

  task automatic test_burst;
    do_reset();
    cycle(8'b101_0_0001, 0);
    n_chk++;
    if ({busy, wr_en} !== {BURST_ON, 3'b000}) begin n_fail++; $display("FAIL burst_begin: got %b want %b", {busy, wr_en}, {BURST_ON, 3'b000}); end
    if (BURST_ON) begin
      for (int i = 0; i < 16; i++) begin
        if (i == 5 || i == 10) begin
          cycle(8'h00, 8'hFF);
          n_chk++;
          if ({wr_en, busy} !== 4'b0001) begin n_fail++; $display("FAIL burst_stall: got %b want 0001", {wr_en, busy}); end
        end
        cycle(8'h10, 8'(i));
        n_chk++;
        if ({wr_en, wr_addr, wr_data, burst_done, busy} !== {3'b010, 4'(i), 8'(i), i == 15, i != 15})
          begin n_fail++; $display("FAIL burst_wr%0d: got %h want %h", i, {wr_en, wr_addr, wr_data, burst_done, busy}, {3'b010, 4'(i), 8'(i), i == 15, i != 15}); end
      end
      cycle(8'h10, 8'h77);
      n_chk++;
      if ({wr_en, busy, burst_done, err} !== 6'd0) begin n_fail++; $display("FAIL burst_after: got %b want 0", {wr_en, busy, burst_done, err}); end
    end else begin
      n_chk++;
      if (err !== 1'b1) begin n_fail++; $display("FAIL burst_disabled_err: got %b want 1", err); end
    end
  endtask

  task automatic test_abort;
    bit done_seen;
    do_reset();
    done_seen = 0;
    cycle(8'b101_0_0000, 0);
    for (int i = 0; i < 4; i++) begin cycle(8'h10, 8'(8'h40 + i)); done_seen |= burst_done; end
    cycle(8'b110_1_0000, 8'h99); done_seen |= burst_done;
    n_chk++;
    if ({wr_en, busy} !== 4'b0000) begin n_fail++; $display("FAIL abort_cycle: got %b want 0000", {wr_en, busy}); end
    cycle(8'h10, 8'h55); done_seen |= burst_done;
    n_chk++;
    if ({wr_en, done_seen} !== 4'b0000) begin n_fail++; $display("FAIL abort_idle: got %b want 0000", {wr_en, done_seen}); end
    cycle(8'b011_0_0011, 8'h5A);
    n_chk++;
    if ({wr_en, wr_addr, wr_data, err} !== {3'b100, 4'd3, 8'h5A, ~BURST_ON})
      begin n_fail++; $display("FAIL abort_then_wr: got %h want %h", {wr_en, wr_addr, wr_data, err}, {3'b100, 4'd3, 8'h5A, ~BURST_ON}); end
  endtask

  task automatic test_async_reset;
    do_reset();
    if (BURST_ON) begin cycle(8'b101_0_0010, 0); cycle(8'h10, 8'h33); end
    else cycle(8'b001_0_0111, 8'h33);
    cycle(8'b111_0_0000, 0);
    if (!BURST_ON) cycle(8'b001_0_0111, 8'h34);
    else cycle(8'h10, 8'h34);
    n_chk++;
    if ({wr_en !== 3'b000, err} !== 2'b11) begin n_fail++; $display("FAIL pre_reset_active: got %b want 11", {wr_en !== 3'b000, err}); end
    reset = 1;
    #1;
    n_chk++;
    if ({wr_en, wr_addr, wr_data, start, busy, burst_done, err} !== 19'd0)
      begin n_fail++; $display("FAIL async_reset: got %h want 0", {wr_en, wr_addr, wr_data, start, busy, burst_done, err}); end
    #1 reset = 0; mreset();
    cycle(8'h10, 8'h66);
    n_chk++;
    if ({wr_en, busy, burst_done} !== 5'd0) begin n_fail++; $display("FAIL post_reset_idle: got %b want 0", {wr_en, busy, burst_done}); end
    cycle(8'b111_0_0000, 0);
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL rsv_err: got %b want 1", err); end
    for (int i = 0; i < 3; i++) cycle(8'(8'h20 + i), 8'h00);
    n_chk++;
    if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
  endtask

  task automatic test_params;
    do_reset();
    uio2 = 8'b010_0_1001; ui2 = 8'hC3;
    @(posedge clk); #1;
    n_chk++;
    if ({we2, wa2, wd2, er2} !== {2'b10, 4'd9, 8'hC3, 1'b0})
      begin n_fail++; $display("FAIL p_valid_wr: got %h want %h", {we2, wa2, wd2, er2}, {2'b10, 4'd9, 8'hC3, 1'b0}); end
    uio2 = 8'b011_0_0000;
    @(posedge clk); #1;
    n_chk++;
    if ({we2, er2} !== 3'b001) begin n_fail++; $display("FAIL p_bad_ch: got %b want 001", {we2, er2}); end
    do_reset();
    uio2 = 8'b001_0_1100;
    @(posedge clk); #1;
    n_chk++;
    if ({we2, er2} !== 3'b001) begin n_fail++; $display("FAIL p_bad_addr: got %b want 001", {we2, er2}); end
    do_reset();
    uio2 = 8'b101_0_0010;
    @(posedge clk); #1;
    n_chk++;
    if ({bz2, er2} !== 2'b01) begin n_fail++; $display("FAIL p_burst_ch: got %b want 01", {bz2, er2}); end
    do_reset();
  endtask

  task automatic test_random;
    logic [7:0] u;
    int r;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (k % 64 == 63) do_reset();
      r = $urandom_range(0, 19);
      u = {(r < 12) ? 3'd0 : 3'(r - 12), 5'($urandom)};
      cycle(u, 8'($urandom));
      n_chk++;
      if ({wr_en, start, busy, burst_done, err} !== {e_we, e_start, e_busy, e_done, e_err})
        begin n_fail++; $display("FAIL rand_ctl k=%0d u=%h: got %b want %b", k, u, {wr_en, start, busy, burst_done, err}, {e_we, e_start, e_busy, e_done, e_err}); end
      if (e_we != 0) begin
        n_chk++;
        if ({wr_addr, wr_data} !== {e_addr, e_data})
          begin n_fail++; $display("FAIL rand_wr k=%0d: got %h want %h", k, {wr_addr, wr_data}, {e_addr, e_data}); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_start();
    test_burst();
    test_abort();
    test_async_reset();
    test_params();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dma_loader.md
DMA_LOADER -- requirements
Module: dma_loader

Interface
REQ-001 Parameter DATA_W, default 8: width of the ui_in data bus and of wr_data.
REQ-002 Parameter ADDR_W, default 4: width of the address field and of wr_addr.
REQ-003 Parameter DEPTH, default 16: number of valid word addresses per channel; legal range 1..2^ADDR_W.
REQ-004 Parameter NUM_CH, default 3: number of destination buffers (0 = weight, 1 = input, 2 = instruction); legal range 1..3.
REQ-005 Port clk, input, 1 bit: single clock; all state is updated on its rising edge.
REQ-006 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 Port uio_in, input, 8 bits: bits [7:5] carry the opcode, bit [4] carries the burst data strobe, bits [ADDR_W-1:0] carry the address or the channel select.
REQ-008 Port ui_in, input, DATA_W bits: write data.
REQ-009 Port wr_en, output, NUM_CH bits: one-hot buffer write enable.
REQ-010 Port wr_addr, output, ADDR_W bits: buffer write address.
REQ-011 Port wr_data, output, DATA_W bits: buffer write data.
REQ-012 Port start, output, 1 bit: compute start pulse.
REQ-013 Port busy, output, 1 bit: high while a burst is in progress.
REQ-014 Port burst_done, output, 1 bit: one-cycle pulse when a burst completes.
REQ-015 Port err, output, 1 bit: sticky error flag.

Function
REQ-016 Opcodes: 000 = NOP; 001/010/011 = single write to channel 0/1/2; 100 = START; 101 = BURST_BEGIN; 110 = ABORT; 111 = reserved.
REQ-017 All outputs shall be registered; every response appears exactly one cycle after the sampling edge.
REQ-018 The FSM shall have two states, IDLE and BURST.
REQ-019 Single write in IDLE: the cycle after sampling, wr_en[op-1]=1, wr_addr=uio_in[ADDR_W-1:0], wr_data=ui_in.
  - The write repeats every cycle the opcode is held.
REQ-020 Single write with channel >= NUM_CH or address >= DEPTH: no wr_en; err is set.
REQ-021 START in IDLE: start is high for exactly one cycle, only on the first cycle of a run of consecutive START opcodes.
REQ-022 BURST_BEGIN in IDLE with uio_in[1:0] < NUM_CH: enter BURST, latch the channel, clear the address counter to 0, set busy.
  - uio_in[1:0] >= NUM_CH instead sets err and stays in IDLE.
REQ-023 In BURST, each cycle with uio_in[4]=1 and opcode other than ABORT:
  - writes ui_in to the latched channel at the counter address on the next cycle;
  - increments the counter.
  - Cycles with uio_in[4]=0 are stalls with no write.
REQ-024 The strobed write at counter address DEPTH-1 completes the burst: that write occurs, burst_done pulses in the same output cycle, busy falls, the FSM returns to IDLE. The counter never wraps.
REQ-025 ABORT in BURST: return to IDLE next cycle, busy=0, no write, no burst_done. ABORT in IDLE is a NOP.
REQ-026 In BURST, opcodes 001–100 and 101 are ignored except ABORT; START or single-write opcodes also set err.
REQ-027 Reserved opcode 111 in any state sets err and has no other effect.
REQ-028 err remains set until reset.
REQ-029 At most one wr_en bit shall be high in any cycle.

Reset
REQ-030 Asserting reset shall immediately force state=IDLE, counter=0, latched channel=0, and wr_en, wr_addr, wr_data, start, busy, burst_done, err all to 0, regardless of the clock.
REQ-031 Reset asserted mid-burst abandons the burst: no burst_done, no further writes.
REQ-032 The first opcode after reset deassertion is sampled on the first rising clock edge with reset low.
REQ-033 The START edge detector shall treat the pre-reset opcode as NOP.

Configuration
REQ-034 Macro DMA_LOADER_BURST_EN: when defined, BURST state, counter, busy and burst_done are implemented as specified.
REQ-035 When DMA_LOADER_BURST_EN is undefined:
  - opcode 101 is treated as reserved (sets err);
  - busy and burst_done are tied to 0;
  - single writes and START are unchanged.

Verification
REQ-036 Reset, then uio_in=8'b001_0_0101, ui_in=8'hA5 for one cycle -> next cycle wr_en=3'b001, wr_addr=5, wr_data=8'hA5; err=0.
REQ-037 uio_in opcode 100 held 3 cycles -> start high exactly one cycle, one cycle after the first; opcode NOP then 100 again -> a second single pulse.
REQ-038 BURST_BEGIN channel 1, then 16 strobed data 0x00..0x0F with 2 stall cycles inserted -> writes to addresses 0..15 of wr_en=3'b010 in order, burst_done coincident with the address-15 write, busy low afterwards.
REQ-039 BURST_BEGIN, 4 strobed writes, then ABORT -> no write for the ABORT cycle, busy=0, burst_done never pulses; a following single write to channel 2 addr 3 succeeds.
REQ-040 Reset asserted asynchronously mid-burst (between clock edges) -> all outputs 0 before the next edge; opcode 111 afterwards -> err=1 and it stays 1 until the next reset.
REQ-041 Parameters NUM_CH=2, DEPTH=10: single write to channel 2 or to address 12 -> no wr_en, err=1; with DMA_LOADER_BURST_EN undefined, opcode 101 -> err=1, busy stays 0.
